// File: rtl/exec_sequencer_pkg.sv
// exec_sequencer_pkg: shared opcodes, sequencer state encoding and opcode helper.
// Ports: none (package). Used by exec_sequencer and exec_sequencer_pc_unit.
// Instruction word layout: [23:16] opcode, [15:8] operand/target, [7:0] operand.
package exec_sequencer_pkg;
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDR = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h02;
    localparam logic [7:0] OP_SUB = 8'h03;
    localparam logic [7:0] OP_INC = 8'h04;
    localparam logic [7:0] OP_DEC = 8'h05;
    localparam logic [7:0] OP_JMP = 8'h10;
    localparam logic [7:0] OP_JZ  = 8'h11;
    localparam logic [7:0] OP_HLT = 8'h1F;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_FETCH = 2'd1,
        SEQ_EXEC  = 2'd2,
        SEQ_HALT  = 2'd3
    } seq_state_t;

    function automatic logic [7:0] opcode(input logic [23:0] word);
        return word[23:16];
    endfunction
endpackage

// File: rtl/exec_sequencer_pc_unit.sv
// exec_sequencer_pc_unit: program counter register with load, increment and hold.
// Ports: clk, rst (sync, active-high) | inc: pc+1 wrapping modulo 2^PC_W |
//        load: pc <= target (wins over inc) | target: jump address | pc: current value.
module exec_sequencer_pc_unit
    import exec_sequencer_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (load)
            pc <= target;
        else if (inc)
            pc <= pc + 1'b1;
    end
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: fetch/execute control unit owning the PC, IR, zero flag and halt state.
// Ports: clk, rst (sync, active-high), run (level run/stop) |
//        rom_req/rom_addr/rom_ack/rom_rdata: instruction fetch handshake |
//        ir: instruction register to decoder | gpr_we_in/gpr_we_out: write enable gated to EXEC |
//        flag_update/alu_zero: zero flag source | pc, exec_valid, halted, z_flag: status.
// Optional: define EXEC_SINGLE_STEP_EN to add input step, which runs one instruction from IDLE.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
`ifdef EXEC_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic            rom_req,
    output logic [PC_W-1:0] rom_addr,
    input  logic            rom_ack,
    input  logic [23:0]     rom_rdata,
    output logic [23:0]     ir,
    input  logic            gpr_we_in,
    output logic            gpr_we_out,
    input  logic            flag_update,
    input  logic            alu_zero,
    output logic [PC_W-1:0] pc,
    output logic            exec_valid,
    output logic            halted,
    output logic            z_flag
);
    seq_state_t state;
    logic       go;
    logic       in_exec;
    logic [7:0] op;

    // A step while run=0 takes the same IDLE->FETCH->EXEC->IDLE path as a run
    // that drops during the fetch; when run=1 the step is redundant.
`ifdef EXEC_SINGLE_STEP_EN
    assign go = run | step;
`else
    assign go = run;
`endif

    assign op         = opcode(ir);
    assign in_exec    = state == SEQ_EXEC;
    assign rom_addr   = pc;
    assign gpr_we_out = gpr_we_in & in_exec;

    // JZ tests the flag as it stood before this EXEC cycle's update.
    exec_sequencer_pc_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .rst    (rst),
        .inc    (in_exec && op != OP_HLT),
        .load   (in_exec && (op == OP_JMP || (op == OP_JZ && z_flag))),
        .target (ir[8 +: PC_W]),
        .pc     (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEQ_IDLE;
            ir         <= '0;
            rom_req    <= 1'b0;
            exec_valid <= 1'b0;
            halted     <= 1'b0;
            z_flag     <= 1'b0;
        end else begin
            case (state)
                SEQ_IDLE: if (go) begin
                    state   <= SEQ_FETCH;
                    rom_req <= 1'b1;
                end
                SEQ_FETCH: if (rom_ack) begin
                    ir         <= rom_rdata;
                    state      <= SEQ_EXEC;
                    rom_req    <= 1'b0;
                    exec_valid <= 1'b1;
                end
                SEQ_EXEC: begin
                    exec_valid <= 1'b0;
                    if (flag_update)
                        z_flag <= alu_zero;
                    if (op == OP_HLT) begin
                        halted <= 1'b1;
                        state  <= SEQ_HALT;
                    end else begin
                        state   <= run ? SEQ_FETCH : SEQ_IDLE;
                        rom_req <= run;
                    end
                end
                default: state <= SEQ_HALT;
            endcase
        end
    end
endmodule
